cosim_array_deserializer: RTL
=============================

# cosim_array_deserializer

Receive-side counterpart to the cosim array pass-through modules. Accepts a stream of 6-bit packed elements (logic[2:0][1:0]) over a valid/ready handshake, assembles them in row-major order into a 2-packed/2-unpacked array logic[2:0][1:0] [4:0][3:0], and presents the completed array as one frame on an output valid/ready handshake. Sits between a cosim element-stream source and any consumer of whole multidimensional arrays. Exercises sequential array traffic across the cosim boundary.

## Interface
- ROWS, default 5: outer unpacked dimension.
- COLS, default 4: inner unpacked dimension.
- PHI, default 3: outer packed dimension.
- PLO, default 2: inner packed dimension; element width EW = PHI*PLO = 6.
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_elem/in_last valid.
- in_ready  output  1  block can accept an element.
- in_elem  input  logic[PHI-1:0][PLO-1:0]  element payload.
- in_last  input  1  source marks final element of a frame.
- out_valid  output  1  out_array holds a complete frame.
- out_ready  input  1  consumer accepts the frame.
- out_array  output  logic[PHI-1:0][PLO-1:0] [ROWS-1:0][COLS-1:0]  assembled frame.
- frame_err  output  1  one-cycle pulse on framing error.

## Operation
- Element transfer: in_valid && in_ready at a rising edge. Frame transfer: out_valid && out_ready at a rising edge.
- Fill order: index k = 0..ROWS*COLS-1 maps to [row][col] with row = k / COLS, col = k % COLS. Col increments fastest and wraps COLS-1 -> 0 with row+1. First element lands in [0][0], element 19 in [4][3].
- States:
  - FILL: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- FILL, accepted element with k < last, in_last=0: write storage[row][col]; advance counters.
- FILL, accepted element with k < last, in_last=1 (early last): write the element; pulse frame_err next cycle; clear all storage to 0; reset counters to 0; stay in FILL. The frame is dropped.
- FILL, accepted element with k = last (index ROWS*COLS-1): write it; go to HOLD; reset counters. If in_last=0, frame_err also pulses and the frame is still presented.
- HOLD: out_array is stable. On frame transfer, return to FILL. Storage is not cleared; it is overwritten by the next frame.
- There is no overlap: no element is accepted while in HOLD.
- out_array drives storage directly at all times. Its contents are defined only while out_valid=1.

## Timing
- Reset (reset_n=0, asynchronous) sets:
  - state FILL, counters 0, storage all 0;
  - in_ready=1, out_valid=0, frame_err=0, out_array all zeros.
- Reset asserted mid-frame or in HOLD discards the partial or held frame immediately.
- Latency: element 19 accepted at edge N -> out_valid=1 and complete out_array visible after edge N.
- out_ready sampled high at edge M in HOLD -> in_ready=1 after edge M. The next element is accepted at edge M+1 or later.
- Best-case throughput: ROWS*COLS+1 cycles per frame (21 at defaults).
- frame_err is registered: high for exactly the cycle after the offending acceptance edge.
- in_ready and out_valid are functions of state only, with no combinational path from in_valid or out_ready.
- in_valid=0 cycles (bubbles) at any point hold all state.

## Structure
- Package cosim_array_pkg holds:
  - ROWS/COLS/PHI/PLO default localparams and EW;
  - typedef cosim_elem_t = logic[PHI-1:0][PLO-1:0];
  - the state enum {FILL, HOLD}.
- Sub-module cosim_array_index_counter holds the row/col counters:
  - inputs: inc, clr;
  - outputs: row, col, at_last.
  - Row and col widths are $clog2 of their dimension, minimum 1.
- The top level holds the FSM, storage array, and error pulse.

## Test plan
- Reset then 20 elements with value k%64 back-to-back, in_last on k=19, out_ready=1:
  - out_valid rises the cycle after k=19;
  - out_array[r][c] == 4r+c;
  - frame held exactly one cycle; in_ready returns 1 the cycle after.
- Same frame with random in_valid bubbles and out_ready held low 5 cycles:
  - out_array stable and in_ready=0 throughout the stall;
  - transfer completes when out_ready rises.
- in_last on k=7:
  - frame_err single-cycle pulse;
  - no out_valid;
  - next 20-element frame lands starting at [0][0] with correct contents.
- Element 19 sent without in_last:
  - frame_err pulses;
  - out_valid=1 with correct contents.
- Assert reset_n=0 asynchronously after 10 elements:
  - outputs return to reset values without waiting for a clock edge;
  - a following full frame assembles correctly.
- Two consecutive frames with distinct patterns (k, then 63-k):
  - second frame's out_array contains no residue from the first.

Source files
------------

// File: rtl/cosim_array_pkg.sv
// Shared parameters, element type and FSM state for the cosim array
// deserializer and its index counter.
package cosim_array_pkg;

   localparam int ROWS = 5;
   localparam int COLS = 4;
   localparam int PHI  = 3;
   localparam int PLO  = 2;
   localparam int EW   = PHI * PLO;

   typedef logic [PHI-1:0][PLO-1:0] cosim_elem_t;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_e;

   // Counter width for a dimension of n entries, never below one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cosim_array_index_counter.sv
// Row-major row/col position tracker for the frame being assembled;
// col runs fastest and wraps into the next row.
module cosim_array_index_counter
   import cosim_array_pkg::*;
#(
   parameter int ROWS = cosim_array_pkg::ROWS,
   parameter int COLS = cosim_array_pkg::COLS,
   localparam int RW = idx_w(ROWS),
   localparam int CW = idx_w(COLS)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          inc,
   input  logic          clr,
   output logic [RW-1:0] row,
   output logic [CW-1:0] col,
   output logic          at_last
);

   localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
   localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clr) begin
         row_d = '0;
         col_d = '0;
      end else if (inc) begin
         if (col_q == COL_MAX) begin
            col_d = '0;
            row_d = row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign row     = row_q;
   assign col     = col_q;
   assign at_last = (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule

// File: rtl/cosim_array_deserializer.sv
// Assembles a stream of packed elements into a whole ROWSxCOLS frame
// and hands it over on an output valid/ready handshake.
module cosim_array_deserializer
   import cosim_array_pkg::*;
#(
   parameter int ROWS = cosim_array_pkg::ROWS,
   parameter int COLS = cosim_array_pkg::COLS,
   parameter int PHI  = cosim_array_pkg::PHI,
   parameter int PLO  = cosim_array_pkg::PLO
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [PHI-1:0][PLO-1:0] in_elem,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [PHI-1:0][PLO-1:0] out_array [ROWS-1:0][COLS-1:0],
   output logic                    frame_err
);

   localparam int RW = idx_w(ROWS);
   localparam int CW = idx_w(COLS);

   typedef logic [PHI-1:0][PLO-1:0] elem_t;

   state_e        state_q, state_d;
   elem_t         storage_q [ROWS-1:0][COLS-1:0];
   elem_t         storage_d [ROWS-1:0][COLS-1:0];
   logic          frame_err_q, frame_err_d;
   logic          inc, clr, at_last;
   logic [RW-1:0] row;
   logic [CW-1:0] col;

   cosim_array_index_counter #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_idx (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (inc),
      .clr     (clr),
      .row     (row),
      .col     (col),
      .at_last (at_last)
   );

   always_comb begin
      state_d     = state_q;
      storage_d   = storage_q;
      frame_err_d = 1'b0;
      inc         = 1'b0;
      clr         = 1'b0;
      unique case (state_q)
         FILL: begin
            if (in_valid) begin
               storage_d[row][col] = in_elem;
               // Error when in_last disagrees with the frame position.
               frame_err_d = at_last ^ in_last;
               if (at_last) begin
                  clr     = 1'b1;
                  state_d = HOLD;
               end else if (in_last) begin
                  clr       = 1'b1;
                  storage_d = '{default: '0};
               end else begin
                  inc = 1'b1;
               end
            end
         end
         HOLD: begin
            if (out_ready) state_d = FILL;
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= FILL;
         storage_q   <= '{default: '0};
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         storage_q   <= storage_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign in_ready  = (state_q == FILL);
   assign out_valid = (state_q == HOLD);
   assign out_array = storage_q;
   assign frame_err = frame_err_q;

endmodule
